// File: rtl/vga_linebuf_timing.sv
// -----------------------------------------------------------------------------
// vga_linebuf_timing
// Video timing generator with a ping-pong line buffer. It sits between the
// PPU pixel stream and the TMDS transmitter. One of every IN_DECIM valid
// input samples is kept and written into the write bank. At every output
// line end the banks swap if a full line is ready. If no full line is ready,
// the previous line is replayed. Timing starts on the first completed line.
//
// Ports
//   clk           in   pixel clock, every register on the rising edge
//   rst_n         in   synchronous reset, active low
//   pix_in        in   input pixel, CH_N channels of CH_W bits, channel 0 in LSBs
//   pix_in_valid  in   qualifies pix_in
//   line_in_start in   first sample of an input line (together with pix_in_valid)
//   pix_out       out  output pixel, 0 while blanked
//   hsync_out     out  horizontal sync, active level HS_POL
//   vsync_out     out  vertical sync, active level VS_POL
//   blank_out     out  1 outside the visible area
//   frame_start   out  pulse together with the first visible pixel of a frame
//   running       out  timing generator active
//   underflow     out  pulse: line end reached with the write line incomplete
//   overflow      out  pulse: kept sample dropped because the write bank is full
// -----------------------------------------------------------------------------
module vga_linebuf_timing #(
    parameter int   CH_W      = 8,
    parameter int   CH_N      = 3,
    parameter int   IN_DECIM  = 2,
    parameter int   H_VISIBLE = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 32,
    parameter logic HS_POL    = 1'b0,
    parameter logic VS_POL    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CH_N*CH_W-1:0] pix_in,
    input  logic                 pix_in_valid,
    input  logic                 line_in_start,
    output logic [CH_N*CH_W-1:0] pix_out,
    output logic                 hsync_out,
    output logic                 vsync_out,
    output logic                 blank_out,
    output logic                 frame_start,
    output logic                 running,
    output logic                 underflow,
    output logic                 overflow
);

    localparam int PIX_W   = CH_N * CH_W;
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);
    localparam int HCX_W   = HC_W + 1;
    localparam int VCX_W   = VC_W + 1;
    localparam int WC_W    = $clog2(H_VISIBLE + 1);
    localparam int PH_W    = (IN_DECIM > 1) ? $clog2(IN_DECIM) : 1;
    localparam int AD_W    = $clog2(2 * H_VISIBLE);
    localparam int DEPTH   = 2 * H_VISIBLE;

    localparam logic [HC_W-1:0]  H_LAST   = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0]  V_LAST   = VC_W'(V_TOTAL - 1);
    localparam logic [HC_W-1:0]  H_VIS_C  = HC_W'(H_VISIBLE);
    localparam logic [VC_W-1:0]  V_VIS_C  = VC_W'(V_VISIBLE);
    localparam logic [HCX_W-1:0] HS_START = HCX_W'(H_VISIBLE + H_FP);
    localparam logic [HCX_W-1:0] HS_END   = HCX_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [VCX_W-1:0] VS_START = VCX_W'(V_VISIBLE + V_FP);
    localparam logic [VCX_W-1:0] VS_END   = VCX_W'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(H_VISIBLE - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(IN_DECIM - 1);

    // Write side state
    logic [PH_W-1:0]  r_phase;
    logic [WC_W-1:0]  r_wr_cnt;
    logic             r_wr_done;
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic             r_running;

    // Timing counters
    logic [HC_W-1:0]  r_h_cnt;
    logic [VC_W-1:0]  r_v_cnt;

    // Line buffer, both banks in one array: bank b occupies [b*H_VISIBLE +: H_VISIBLE]
    logic [PIX_W-1:0] r_mem [0:DEPTH-1];
    logic [PIX_W-1:0] r_rd_data;

    // First pipeline stage (aligned with r_rd_data)
    logic             r_vis_p1;
    logic             r_hs_p1;
    logic             r_vs_p1;
    logic             r_fs_p1;
    logic             r_uf_p1;

    // Output registers
    logic [PIX_W-1:0] r_pix_out;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_blank;
    logic             r_frame_start;
    logic             r_underflow;
    logic             r_overflow;

    // Combinational helpers
    logic [PH_W-1:0]  w_phase_cur;
    logic [PH_W-1:0]  w_phase_nxt;
    logic [WC_W-1:0]  w_wr_cnt_cur;
    logic             w_keep;
    logic             w_wr_en;
    logic             w_drop;
    logic             w_fill_last;
    logic             w_line_end;
    logic             w_swap;
    logic             w_underflow;
    logic [AD_W-1:0]  w_wr_addr;
    logic [AD_W-1:0]  w_rd_addr;
    logic             w_rd_en;
    logic             w_h_vis;
    logic             w_vis;
    logic             w_hs_act;
    logic             w_vs_act;
    logic             w_fs;

    // Decimation, write enable and line-end swap decision
    always_comb begin
        w_phase_cur  = r_phase;
        w_phase_nxt  = r_phase;
        w_wr_cnt_cur = r_wr_cnt;
        if (pix_in_valid && line_in_start) begin
            w_phase_cur = PH_W'(0);
            // A completed line waiting for the swap is never discarded
            if (!r_wr_done) begin
                w_wr_cnt_cur = WC_W'(0);
            end else begin
                w_wr_cnt_cur = r_wr_cnt;
            end
        end else begin
            w_phase_cur  = r_phase;
            w_wr_cnt_cur = r_wr_cnt;
        end
        if (pix_in_valid) begin
            if (w_phase_cur == PH_LAST) begin
                w_phase_nxt = PH_W'(0);
            end else begin
                w_phase_nxt = w_phase_cur + PH_W'(1);
            end
        end else begin
            w_phase_nxt = r_phase;
        end
        w_keep      = pix_in_valid && (w_phase_cur == PH_W'(0));
        w_wr_en     = w_keep && !r_wr_done;
        w_drop      = w_keep && r_wr_done;
        w_fill_last = w_wr_en && (w_wr_cnt_cur == WC_LAST);
        // Before the first swap every cycle is a line end, so timing starts
        // as soon as the first full line lands
        w_line_end  = !r_running || (r_h_cnt == H_LAST);
        w_swap      = w_line_end && (r_wr_done || w_fill_last);
        w_underflow = w_line_end && r_running && !(r_wr_done || w_fill_last);
        if (r_wr_bank) begin
            w_wr_addr = AD_W'(H_VISIBLE) + AD_W'(w_wr_cnt_cur);
        end else begin
            w_wr_addr = AD_W'(w_wr_cnt_cur);
        end
    end

    // Counter decode for the visible area, syncs and read address
    always_comb begin
        w_h_vis  = (r_h_cnt < H_VIS_C);
        w_vis    = r_running && w_h_vis && (r_v_cnt < V_VIS_C);
        w_hs_act = r_running && ({1'b0, r_h_cnt} >= HS_START) && ({1'b0, r_h_cnt} < HS_END);
        w_vs_act = r_running && ({1'b0, r_v_cnt} >= VS_START) && ({1'b0, r_v_cnt} < VS_END);
        w_fs     = r_running && (r_h_cnt == HC_W'(0)) && (r_v_cnt == VC_W'(0));
        w_rd_en  = r_running && w_h_vis;
        if (r_rd_bank) begin
            w_rd_addr = AD_W'(H_VISIBLE) + AD_W'(r_h_cnt);
        end else begin
            w_rd_addr = AD_W'(r_h_cnt);
        end
    end

    // Write pointer, bank swap and running flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase   <= PH_W'(0);
            r_wr_cnt  <= WC_W'(0);
            r_wr_done <= 1'b0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            if (w_swap) begin
                // The last sample of the line may be written in this very cycle
                r_rd_bank <= r_wr_bank;
                r_wr_bank <= ~r_wr_bank;
                r_wr_cnt  <= WC_W'(0);
                r_wr_done <= 1'b0;
                r_running <= 1'b1;
            end else if (w_wr_en) begin
                r_wr_cnt  <= w_wr_cnt_cur + WC_W'(1);
                r_wr_done <= w_fill_last;
            end else begin
                r_wr_cnt  <= w_wr_cnt_cur;
                r_wr_done <= r_wr_done;
            end
        end
    end

    // Horizontal and vertical counters, frozen at 0 until running
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h_cnt <= HC_W'(0);
            r_v_cnt <= VC_W'(0);
        end else if (r_running) begin
            if (r_h_cnt == H_LAST) begin
                r_h_cnt <= HC_W'(0);
                if (r_v_cnt == V_LAST) begin
                    r_v_cnt <= VC_W'(0);
                end else begin
                    r_v_cnt <= r_v_cnt + VC_W'(1);
                end
            end else begin
                r_h_cnt <= r_h_cnt + HC_W'(1);
            end
        end else begin
            r_h_cnt <= HC_W'(0);
            r_v_cnt <= VC_W'(0);
        end
    end

    // Line buffer memory: one write port, one synchronous read port, no reset
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= pix_in;
        end
        if (w_rd_en) begin
            r_rd_data <= r_mem[w_rd_addr];
        end
    end

    // Two-stage output pipeline keeping every output aligned with the pixel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vis_p1      <= 1'b0;
            r_hs_p1       <= 1'b0;
            r_vs_p1       <= 1'b0;
            r_fs_p1       <= 1'b0;
            r_uf_p1       <= 1'b0;
            r_pix_out     <= PIX_W'(0);
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_blank       <= 1'b1;
            r_frame_start <= 1'b0;
            r_underflow   <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_vis_p1      <= w_vis;
            r_hs_p1       <= w_hs_act;
            r_vs_p1       <= w_vs_act;
            r_fs_p1       <= w_fs;
            r_uf_p1       <= w_underflow;
            r_pix_out     <= r_vis_p1 ? r_rd_data : PIX_W'(0);
            r_hsync       <= r_hs_p1 ? HS_POL : ~HS_POL;
            r_vsync       <= r_vs_p1 ? VS_POL : ~VS_POL;
            r_blank       <= ~r_vis_p1;
            r_frame_start <= r_fs_p1;
            r_underflow   <= r_uf_p1;
            // Overflow is a write-side event and is reported one cycle after the drop
            r_overflow    <= w_drop;
        end
    end

    assign pix_out     = r_pix_out;
    assign hsync_out   = r_hsync;
    assign vsync_out   = r_vsync;
    assign blank_out   = r_blank;
    assign frame_start = r_frame_start;
    assign running     = r_running;
    assign underflow   = r_underflow;
    assign overflow    = r_overflow;

endmodule
